calc_key_alu: RTL
=================

CALC_KEY_ALU -- requirements
Module: calc_key_alu

Interface
REQ-001 Parameter MAX_RESULT, default 9999, largest displayable result; any larger result is an error.
REQ-002 Parameter OPND_MAX, default 99, largest operand value (two decimal digits).
REQ-003 clk  input  1  block clock, the same divided clock that drives the LCD sequencer.
REQ-004 rst  input  1  reset; one clock, synchronous, active-high.
REQ-005 i_sw_push  input  12  debounced push keys; bits 0-9 = digits 0-9, bit 10 = OP, bit 11 = EQ.
REQ-006 i_sw_dip  input  3  operator select, latched on OP: 0 add, 1 sub, 2 mul, 3 div, 4 rem, 5 pow, 6 fac, 7 reserved.
REQ-007 o_opnd_a  output  7  operand A, 0..99.
REQ-008 o_opnd_b  output  7  operand B, 0..99.
REQ-009 o_op  output  3  latched operator code.
REQ-010 o_result  output  14  result magnitude, 0..MAX_RESULT.
REQ-011 o_neg  output  1  result is negative (sub only).
REQ-012 o_err  output  1  error flag, held while in ERROR.
REQ-013 o_done  output  1  one-cycle pulse on entry to DONE or ERROR.
REQ-014 o_state  output  3  state code: ENTER_A=0, ENTER_B=1, COMPUTE=2, DONE=3, ERROR=4.

Function
REQ-015 Key events SHALL be detected from a registered copy of i_sw_push: evt = i_sw_push & ~prev; the event takes effect at the same clock edge that samples it.
REQ-016 A cycle with zero evt bits, or with more than one, SHALL be ignored entirely.
REQ-017 Digit d in ENTER_A SHALL set A <= (A mod 10)*10 + d, so only the last two digits are kept.
REQ-018 Digit d in ENTER_B SHALL set B the same way.
REQ-019 OP in ENTER_A SHALL latch o_op <= i_sw_dip and move to ENTER_B with B unchanged (0).
REQ-020 OP in ENTER_B SHALL re-latch o_op and keep the state.
REQ-021 EQ SHALL be ignored in ENTER_A, DONE and ERROR.
REQ-022 EQ in ENTER_B SHALL move to COMPUTE.
REQ-023 In COMPUTE, all key events SHALL be ignored.
REQ-024 add, sub, mul, div and rem SHALL complete in one cycle: COMPUTE for 1 cycle, then DONE.
REQ-025 sub with B>A SHALL give o_result=B-A and o_neg=1; all other operations SHALL give o_neg=0.
REQ-026 div and rem SHALL be integer quotient and remainder of A by B; B=0 SHALL go to ERROR.
REQ-027 pow SHALL be iterative: acc starts at 1 and is multiplied by A once per cycle, B times; COMPUTE lasts max(B,1) cycles; 0^0=1.
REQ-028 pow SHALL go to ERROR in the cycle acc would exceed MAX_RESULT.
REQ-029 fac SHALL compute A! iteratively, one multiply per cycle, ignoring B; COMPUTE lasts max(A,1) cycles; 0!=1.
REQ-030 fac with A>7 SHALL go to ERROR after 1 cycle.
REQ-031 Opcode 7 SHALL go to ERROR after 1 cycle.
REQ-032 On entering ERROR: o_err=1, o_result=0, o_neg=0.
REQ-033 Digit d in DONE or ERROR SHALL start a new calculation: A<=d, B<=0, o_result<=0, o_neg<=0, o_err<=0, o_op unchanged, state ENTER_A.
REQ-034 OP in DONE or ERROR SHALL be ignored.
REQ-035 o_done SHALL pulse exactly once per COMPUTE, for the cycle after the final COMPUTE cycle.
REQ-036 Operands, op, result and flags SHALL be registered outputs, and SHALL hold stable in DONE so the LCD may sample them at any time.

Reset
REQ-037 rst=1 at a clock edge SHALL force: state ENTER_A, A=B=0, o_op=0, o_result=0, o_neg=0, o_err=0, o_done=0, prev=0.
REQ-038 Reset mid-COMPUTE SHALL abort the iteration with no o_done pulse.
REQ-039 A key held through reset release SHALL produce an event on the first post-reset cycle (prev=0).

Verification
REQ-040 Keys 1,2,OP(dip=0),3,4,EQ -> A=12, B=34, COMPUTE 1 cycle, o_result=46, o_done pulse, state 3.
REQ-041 A=5, OP(dip=1), B=9, EQ -> o_result=4, o_neg=1; then digit 7 -> state 0, A=7, o_neg=0.
REQ-042 A=2, OP(dip=5), B=10, EQ -> COMPUTE 10 cycles, o_result=1024.
REQ-043 A=10, OP(dip=5), B=4, EQ -> ERROR, o_err=1, o_result=0.
REQ-044 A=7, OP(dip=3), B=0, EQ -> ERROR.
REQ-045 A=7, OP(dip=6), EQ -> o_result=5040 after 7 COMPUTE cycles.
REQ-046 Digits 1,2,3 -> A=23.
REQ-047 Keys 4 and 5 pressed in the same cycle -> no change.
REQ-048 rst asserted during the 3rd pow cycle -> all outputs 0, no o_done.

Source files
------------

// File: rtl/calc_key_alu_if.sv
// Key/operator inputs and display-facing outputs of the calculator key ALU.
// master drives the keys (board or bench); slave is the ALU.
interface calc_key_alu_if;
  logic [11:0] i_sw_push;
  logic [2:0]  i_sw_dip;
  logic [6:0]  o_opnd_a;
  logic [6:0]  o_opnd_b;
  logic [2:0]  o_op;
  logic [13:0] o_result;
  logic        o_neg;
  logic        o_err;
  logic        o_done;
  logic [2:0]  o_state;

  modport master (
    output i_sw_push, i_sw_dip,
    input  o_opnd_a, o_opnd_b, o_op, o_result, o_neg, o_err, o_done, o_state
  );

  modport slave (
    input  i_sw_push, i_sw_dip,
    output o_opnd_a, o_opnd_b, o_op, o_result, o_neg, o_err, o_done, o_state
  );
endinterface

// File: rtl/calc_key_alu.sv
// Two-operand decimal calculator driven by edge-detected push keys.
// pow and fac iterate one multiply per clock; everything else resolves in one COMPUTE cycle.
module calc_key_alu #(
  parameter int MAX_RESULT = 9999,
  parameter int OPND_MAX   = 99
) (
  input  logic          clk,
  input  logic          rst,
  calc_key_alu_if.slave bus
);

  typedef enum logic [2:0] {
    ENTER_A = 3'd0,
    ENTER_B = 3'd1,
    COMPUTE = 3'd2,
    DONE    = 3'd3,
    ERROR   = 3'd4
  } state_t;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_REM = 3'd4;
  localparam logic [2:0] OP_POW = 3'd5;
  localparam logic [2:0] OP_FAC = 3'd6;

  localparam logic [20:0] MAX_W    = 21'(MAX_RESULT);
  localparam logic [6:0]  OPND_LIM = 7'(OPND_MAX);

  state_t      state_reg, state_next;
  logic [11:0] prev_reg;
  logic [6:0]  a_reg, a_next;
  logic [6:0]  b_reg, b_next;
  logic [2:0]  op_reg, op_next;
  logic [13:0] result_reg, result_next;
  logic        neg_reg, neg_next;
  logic        err_reg, err_next;
  logic        done_reg, done_next;
  logic [13:0] acc_reg, acc_next;
  logic [6:0]  cnt_reg, cnt_next;

  // Key decode: only cycles with exactly one new key press count.
  logic [11:0] evt;
  logic        single_key, is_digit, is_op, is_eq;
  logic [3:0]  digit;

  assign evt        = bus.i_sw_push & ~prev_reg;
  assign single_key = (evt != 12'd0) && ((evt & (evt - 12'd1)) == 12'd0);
  assign is_digit   = single_key && (|evt[9:0]);
  assign is_op      = single_key && evt[10];
  assign is_eq      = single_key && evt[11];

  always_comb begin
    digit = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (evt[i]) digit = 4'(i);
    end
  end

  // Shift-in keeps only the last two decimal digits of the operand.
  logic [6:0] a_shift, b_shift, a_entered, b_entered;
  assign a_shift   = (a_reg % 7'd10) * 7'd10 + {3'b000, digit};
  assign b_shift   = (b_reg % 7'd10) * 7'd10 + {3'b000, digit};
  assign a_entered = (a_shift > OPND_LIM) ? {3'b000, digit} : a_shift;
  assign b_entered = (b_shift > OPND_LIM) ? {3'b000, digit} : b_shift;

  logic [20:0] a_w, b_w, sum_w, mul_w, iter_w;
  logic [6:0]  quot, rem, iter_rhs;

  assign a_w      = {14'd0, a_reg};
  assign b_w      = {14'd0, b_reg};
  assign sum_w    = a_w + b_w;
  assign mul_w    = a_w * b_w;
  assign quot     = (b_reg == 7'd0) ? 7'd0 : a_reg / b_reg;
  assign rem      = (b_reg == 7'd0) ? 7'd0 : a_reg % b_reg;
  // pow multiplies by A each step; fac multiplies by the running index.
  assign iter_rhs = (op_reg == OP_POW) ? a_reg : cnt_reg;
  assign iter_w   = {7'd0, acc_reg} * {14'd0, iter_rhs};

  logic        fin_ok, fin_err, fin_neg;
  logic [20:0] fin_val;

  always_comb begin
    state_next  = state_reg;
    a_next      = a_reg;
    b_next      = b_reg;
    op_next     = op_reg;
    result_next = result_reg;
    neg_next    = neg_reg;
    err_next    = err_reg;
    done_next   = 1'b0;
    acc_next    = acc_reg;
    cnt_next    = cnt_reg;
    fin_ok      = 1'b0;
    fin_err     = 1'b0;
    fin_neg     = 1'b0;
    fin_val     = 21'd0;

    case (state_reg)
      ENTER_A: begin
        if (is_digit) begin
          a_next = a_entered;
        end else if (is_op) begin
          op_next    = bus.i_sw_dip;
          state_next = ENTER_B;
        end
      end
      ENTER_B: begin
        if (is_digit) begin
          b_next = b_entered;
        end else if (is_op) begin
          op_next = bus.i_sw_dip;
        end else if (is_eq) begin
          acc_next   = 14'd1;
          cnt_next   = (op_reg == OP_FAC) ? 7'd1 : 7'd0;
          state_next = COMPUTE;
        end
      end
      COMPUTE: begin
        case (op_reg)
          OP_ADD: begin
            fin_ok  = 1'b1;
            fin_val = sum_w;
          end
          OP_SUB: begin
            fin_ok = 1'b1;
            if (b_reg > a_reg) begin
              fin_val = b_w - a_w;
              fin_neg = 1'b1;
            end else begin
              fin_val = a_w - b_w;
            end
          end
          OP_MUL: begin
            fin_ok  = 1'b1;
            fin_val = mul_w;
          end
          OP_DIV, OP_REM: begin
            if (b_reg == 7'd0) begin
              fin_err = 1'b1;
            end else begin
              fin_ok  = 1'b1;
              fin_val = {14'd0, (op_reg == OP_DIV) ? quot : rem};
            end
          end
          OP_POW: begin
            if (b_reg == 7'd0) begin
              fin_ok  = 1'b1;
              fin_val = 21'd1;
            end else if (iter_w > MAX_W) begin
              fin_err = 1'b1;
            end else if (cnt_reg == b_reg - 7'd1) begin
              fin_ok  = 1'b1;
              fin_val = iter_w;
            end else begin
              acc_next = iter_w[13:0];
              cnt_next = cnt_reg + 7'd1;
            end
          end
          OP_FAC: begin
            if (a_reg > 7'd7) begin
              fin_err = 1'b1;
            end else if (iter_w > MAX_W) begin
              fin_err = 1'b1;
            end else if (cnt_reg >= a_reg) begin
              fin_ok  = 1'b1;
              fin_val = iter_w;
            end else begin
              acc_next = iter_w[13:0];
              cnt_next = cnt_reg + 7'd1;
            end
          end
          default: fin_err = 1'b1;
        endcase
      end
      DONE, ERROR: begin
        if (is_digit) begin
          a_next      = {3'b000, digit};
          b_next      = 7'd0;
          result_next = 14'd0;
          neg_next    = 1'b0;
          err_next    = 1'b0;
          state_next  = ENTER_A;
        end
      end
      default: state_next = ENTER_A;
    endcase

    // Any out-of-range final value is reported as an error, not truncated.
    if (fin_err || (fin_ok && (fin_val > MAX_W))) begin
      state_next  = ERROR;
      err_next    = 1'b1;
      result_next = 14'd0;
      neg_next    = 1'b0;
      done_next   = 1'b1;
    end else if (fin_ok) begin
      state_next  = DONE;
      result_next = fin_val[13:0];
      neg_next    = fin_neg;
      done_next   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ENTER_A;
      prev_reg   <= 12'd0;
      a_reg      <= 7'd0;
      b_reg      <= 7'd0;
      op_reg     <= 3'd0;
      result_reg <= 14'd0;
      neg_reg    <= 1'b0;
      err_reg    <= 1'b0;
      done_reg   <= 1'b0;
      acc_reg    <= 14'd0;
      cnt_reg    <= 7'd0;
    end else begin
      state_reg  <= state_next;
      prev_reg   <= bus.i_sw_push;
      a_reg      <= a_next;
      b_reg      <= b_next;
      op_reg     <= op_next;
      result_reg <= result_next;
      neg_reg    <= neg_next;
      err_reg    <= err_next;
      done_reg   <= done_next;
      acc_reg    <= acc_next;
      cnt_reg    <= cnt_next;
    end
  end

  assign bus.o_opnd_a = a_reg;
  assign bus.o_opnd_b = b_reg;
  assign bus.o_op     = op_reg;
  assign bus.o_result = result_reg;
  assign bus.o_neg    = neg_reg;
  assign bus.o_err    = err_reg;
  assign bus.o_done   = done_reg;
  assign bus.o_state  = state_reg;

endmodule
